// File: rtl/if_id_queue_pkg.sv
// Shared defaults and helpers for the IF->ID decoupling queue.
package if_id_queue_pkg;

  localparam int IBUF_DEPTH = 4;
  localparam int ADDR_BUS_W = 32;
  localparam int DATA_BUS_W = 32;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Stored entry layout, MSB first: {pc, pcp4, inst, excp}.
  function automatic int entry_w(input int addr_w, input int data_w);
    return 2 * addr_w + data_w + 1;
  endfunction

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-side and decode-side handshake bundle of the IF->ID queue.
interface if_id_queue_if
  import if_id_queue_pkg::*;
#(
  parameter int ADDR_W = ADDR_BUS_W,
  parameter int DATA_W = DATA_BUS_W
);

  // Valid/ready: a transfer happens on a rising edge where both valid and ready are 1.
  // Payload is only meaningful while valid is 1; ready never depends on valid.
  logic              if_valid;
  logic              if_ready;
  logic [ADDR_W-1:0] if_pc;
  logic [ADDR_W-1:0] if_pcp4;
  logic [DATA_W-1:0] if_inst;
  logic              if_excp;

  logic              id_valid;
  logic              id_ready;
  logic              id_isbranch;
  logic [ADDR_W-1:0] id_pc;
  logic [ADDR_W-1:0] id_pcp4;
  logic [DATA_W-1:0] id_inst;
  logic              id_excp;
  logic              id_inslot;

  // master: the fetch unit plus decoder around the queue; slave: the queue itself.
  modport master (
    output if_valid, if_pc, if_pcp4, if_inst, if_excp,
    input  if_ready,
    output id_ready, id_isbranch,
    input  id_valid, id_pc, id_pcp4, id_inst, id_excp, id_inslot
  );

  modport slave (
    input  if_valid, if_pc, if_pcp4, if_inst, if_excp,
    output if_ready,
    input  id_ready, id_isbranch,
    output id_valid, id_pc, id_pcp4, id_inst, id_excp, id_inslot
  );

endinterface

// File: rtl/if_id_queue_mem.sv
// Entry storage for the IF->ID queue: one synchronous write port, one async read port.
module if_id_queue_mem
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = IBUF_DEPTH,
  parameter int WIDTH = entry_w(ADDR_BUS_W, DATA_BUS_W)
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  // No reset on purpose: stale contents are hidden by the top's output gating.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// IF->ID decoupling queue: DEPTH-entry FIFO with valid/ready handshakes, one-cycle
// flush and program-order tracking of the branch-delay-slot bit.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH  = IBUF_DEPTH,
  parameter int ADDR_W = ADDR_BUS_W,
  parameter int DATA_W = DATA_BUS_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  if_id_queue_if.slave           bus,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = entry_w(ADDR_W, DATA_W);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [PTR_W-1:0]   wptr;
  logic [PTR_W-1:0]   rptr;
  logic [CNT_W-1:0]   count;
  logic               slot_pend;
  logic               full;
  logic               enq;
  logic               deq;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;

  assign full         = (count == CNT_W'(DEPTH));
  assign bus.if_ready = ~full;
  assign bus.id_valid = (count != '0);
  assign enq          = bus.if_valid & bus.if_ready;
  assign deq          = bus.id_valid & bus.id_ready;
  assign wr_entry     = {bus.if_pc, bus.if_pcp4, bus.if_inst, bus.if_excp};

  if_id_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .clk   (clk),
    .we    (enq & ~flush),
    .waddr (wptr),
    .wdata (wr_entry),
    .raddr (rptr),
    .rdata (rd_entry)
  );

  // Pointers rely on DEPTH being a power of two, so wrap is plain overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      slot_pend <= FALSE;
    end else if (flush) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      slot_pend <= FALSE;
    end else begin
      if (enq) begin
        wptr <= wptr + PTR_ONE;
      end
      if (deq) begin
        rptr      <= rptr + PTR_ONE;
        slot_pend <= bus.id_isbranch;
      end
      count <= count + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  // An empty queue presents a nop with no fault and no slot marking.
  assign {bus.id_pc, bus.id_pcp4, bus.id_inst, bus.id_excp} =
    bus.id_valid ? rd_entry : '0;
  assign bus.id_inslot = bus.id_valid & slot_pend;
  assign occupancy     = count;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue with a queue-based reference model checked every cycle.
module tb_if_id_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int EW     = 2 * ADDR_W + DATA_W + 1;
  localparam int OCC_W  = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic             flush;
  logic [OCC_W-1:0] occupancy;

  if_id_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  if_id_queue #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .occupancy (occupancy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;

  logic [EW-1:0] exp_q[$];
  logic          m_slot;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [EW-1:0] pack(input logic [31:0] pc, input logic [31:0] inst,
                                         input logic excp);
    return {pc, pc + 32'd4, inst, excp};
  endfunction

  // Reference model: an ordered list of stored entries plus one pending-slot bit.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      m_slot = 1'b0;
    end else if (flush) begin
      exp_q.delete();
      m_slot = 1'b0;
    end else begin
      bit do_enq;
      bit do_deq;
      do_enq = bus.if_valid && (exp_q.size() < DEPTH);
      do_deq = bus.id_ready && (exp_q.size() != 0);
      if (do_deq) begin
        void'(exp_q.pop_front());
        m_slot = bus.id_isbranch;
      end
      if (do_enq) begin
        exp_q.push_back({bus.if_pc, bus.if_pcp4, bus.if_inst, bus.if_excp});
      end
    end
  end

  // Compare process: outputs depend only on state, so the falling edge is a stable point.
  always @(negedge clk) begin
    if (chk_on) begin
      logic [EW-1:0] h;
      bit            v;
      v = (exp_q.size() != 0);
      h = v ? exp_q[0] : '0;
      check("id_valid",  64'(bus.id_valid),  64'(v));
      check("if_ready",  64'(bus.if_ready),  64'(exp_q.size() < DEPTH));
      check("occupancy", 64'(occupancy),     64'(exp_q.size()));
      check("id_pc",     64'(bus.id_pc),     64'(h[EW-1 -: ADDR_W]));
      check("id_pcp4",   64'(bus.id_pcp4),   64'(h[EW-1-ADDR_W -: ADDR_W]));
      check("id_inst",   64'(bus.id_inst),   64'(h[DATA_W:1]));
      check("id_excp",   64'(bus.id_excp),   64'(h[0]));
      check("id_inslot", 64'(bus.id_inslot), 64'(v & m_slot));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_fetch(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                           input logic excp);
    bus.if_valid = v;
    bus.if_pc    = pc;
    bus.if_pcp4  = pc + 32'd4;
    bus.if_inst  = inst;
    bus.if_excp  = excp;
  endtask

  task automatic set_dec(input logic rdy, input logic br);
    bus.id_ready    = rdy;
    bus.id_isbranch = br;
  endtask

  task automatic idle();
    set_fetch(1'b0, 32'h0, 32'h0, 1'b0);
    set_dec(1'b0, 1'b0);
    flush = 1'b0;
  endtask

  task automatic enq_one(input logic [31:0] pc, input logic [31:0] inst);
    set_fetch(1'b1, pc, inst, 1'b0);
    step();
    set_fetch(1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    set_dec(1'b1, 1'b0);
    while (bus.id_valid && guard < 20) begin
      step();
      guard++;
    end
    set_dec(1'b0, 1'b0);
    check("drain_bound", 64'(guard < 20), 64'd1);
  endtask

  logic [31:0] rx_pc[$];
  logic        rx_excp[$];

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    idle();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk_on = 1'b1;

    // Reset state
    check("rst_id_valid",  64'(bus.id_valid),  64'd0);
    check("rst_if_ready",  64'(bus.if_ready),  64'd1);
    check("rst_occupancy", 64'(occupancy),     64'd0);
    check("rst_id_inst",   64'(bus.id_inst),   64'd0);

    // First enqueue visible after one edge
    enq_one(32'hBFC0_0000, 32'h2408_0001);
    check("first_valid", 64'(bus.id_valid),  64'd1);
    check("first_pc",    64'(bus.id_pc),     64'hBFC0_0000);
    check("first_pcp4",  64'(bus.id_pcp4),   64'hBFC0_0004);
    check("first_inst",  64'(bus.id_inst),   64'h2408_0001);
    check("first_slot",  64'(bus.id_inslot), 64'd0);
    check("first_occ",   64'(occupancy),     64'd1);
    drain();

    // Fill to DEPTH with the decoder stalled
    for (int i = 0; i < DEPTH; i++) begin
      enq_one(32'h8000_0100 + 32'(i * 4), 32'h1100_0000 + 32'(i));
    end
    check("full_if_ready", 64'(bus.if_ready), 64'd0);
    check("full_occ",      64'(occupancy),    64'd4);
    set_fetch(1'b1, 32'h8000_0110, 32'h1100_0004, 1'b0);
    step();
    check("held_occ",  64'(occupancy), 64'd4);
    check("held_head", 64'(bus.id_pc), 64'h8000_0100);
    set_dec(1'b1, 1'b0);
    step();
    check("free_occ",      64'(occupancy),    64'd3);
    check("free_if_ready", 64'(bus.if_ready), 64'd1);
    check("free_head",     64'(bus.id_pc),    64'h8000_0104);
    step();
    check("swap_occ",  64'(occupancy), 64'd3);
    check("swap_head", 64'(bus.id_pc), 64'h8000_0108);
    idle();
    drain();

    // Branch followed by its delay slot
    enq_one(32'h8000_0010, 32'h1000_0003);
    enq_one(32'h8000_0014, 32'h0000_0000);
    enq_one(32'h8000_0018, 32'h2408_0002);
    set_dec(1'b1, 1'b1);
    step();
    check("slot_pc",   64'(bus.id_pc),     64'h8000_0014);
    check("slot_bit",  64'(bus.id_inslot), 64'd1);
    set_dec(1'b1, 1'b0);
    step();
    check("after_pc",  64'(bus.id_pc),     64'h8000_0018);
    check("after_bit", 64'(bus.id_inslot), 64'd0);
    drain();

    // Branch drains the queue; slot instruction arrives three cycles later
    enq_one(32'h8000_0020, 32'h0800_0040);
    set_dec(1'b1, 1'b1);
    step();
    set_dec(1'b0, 1'b0);
    check("empty_slot_gated", 64'(bus.id_inslot), 64'd0);
    step();
    step();
    enq_one(32'h8000_0024, 32'h2409_0003);
    check("late_slot_pc",  64'(bus.id_pc),     64'h8000_0024);
    check("late_slot_bit", 64'(bus.id_inslot), 64'd1);
    drain();

    // Flush with three entries, a simultaneous enqueue and a branch consume
    enq_one(32'h8000_0200, 32'h0800_0080);
    set_dec(1'b1, 1'b1);
    step();
    set_dec(1'b0, 1'b0);
    enq_one(32'h8000_0204, 32'h2400_0001);
    enq_one(32'h8000_0208, 32'h2400_0002);
    enq_one(32'h8000_020C, 32'h2400_0003);
    set_fetch(1'b1, 32'h8000_0210, 32'h2400_0004, 1'b0);
    set_dec(1'b1, 1'b1);
    flush = 1'b1;
    step();
    idle();
    check("flush_valid",    64'(bus.id_valid), 64'd0);
    check("flush_occ",      64'(occupancy),    64'd0);
    check("flush_inst",     64'(bus.id_inst),  64'd0);
    check("flush_if_ready", 64'(bus.if_ready), 64'd1);
    enq_one(32'h8000_0400, 32'h2400_0005);
    check("flush_slot_clear", 64'(bus.id_inslot), 64'd0);
    check("flush_next_pc",    64'(bus.id_pc),     64'h8000_0400);
    drain();

    // Wrap: stream 10 entries with a random decoder; entry 7 carries a fetch fault
    begin
      int idx;
      int cyc;
      bit acc;
      idx = 1;
      cyc = 0;
      while (rx_pc.size() < 10 && cyc < 300) begin
        set_fetch(idx <= 10, 32'h8000_1000 + 32'(idx * 4), 32'hA000_0000 + 32'(idx), idx == 7);
        set_dec(1'($urandom_range(0, 1)), 1'b0);
        acc = bus.if_valid && bus.if_ready;
        if (bus.id_valid && bus.id_ready) begin
          rx_pc.push_back(bus.id_pc);
          rx_excp.push_back(bus.id_excp);
        end
        step();
        if (acc) idx++;
        cyc++;
      end
      idle();
      check("stream_bound", 64'(cyc < 300), 64'd1);
      check("stream_count", 64'(rx_pc.size()), 64'd10);
      for (int k = 0; k < rx_pc.size(); k++) begin
        check("stream_pc",   64'(rx_pc[k]),   64'(32'h8000_1000 + 32'((k + 1) * 4)));
        check("stream_excp", 64'(rx_excp[k]), 64'(k + 1 == 7));
      end
    end

    // Asynchronous reset mid-stream
    enq_one(32'h8000_2000, 32'h2400_0010);
    enq_one(32'h8000_2004, 32'h2400_0011);
    #2 rst = 1'b0;
    #1;
    check("arst_valid", 64'(bus.id_valid), 64'd0);
    check("arst_occ",   64'(occupancy),    64'd0);
    check("arst_pc",    64'(bus.id_pc),    64'd0);
    @(negedge clk);
    rst = 1'b1;
    enq_one(32'h8000_3000, 32'h2400_0020);
    check("post_rst_occ", 64'(occupancy), 64'd1);
    check("post_rst_pc",  64'(bus.id_pc), 64'h8000_3000);
    drain();

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
